// File: rtl/scan_deserializer.sv
// ==== scan_deserializer: slot-based serial-to-parallel receiver, 8 slots of 2^SLOT_BITS cycles, LSB first
// ==== Rev 1.0 | optional SYNC_FLYWHEEL_EN: tolerate up to two consecutive missing syncs
`default_nettype none

module scan_deserializer #(
  parameter int SLOT_BITS = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_in,
  input  logic       sync,
  output logic [7:0] Q,
  output logic       valid,
  output logic [7:0] slot_oh,
  output logic       locked,
  output logic       frame_err
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [SLOT_BITS-1:0] C_MID  = {1'b1, {(SLOT_BITS-1){1'b0}}};
  localparam logic [SLOT_BITS-1:0] C_LAST = '1;
  localparam logic [SLOT_BITS-1:0] C_ONE  = {{(SLOT_BITS-1){1'b0}}, 1'b1};

  state_t               state;
  logic [SLOT_BITS-1:0] cyc_cnt;
  logic [2:0]           slot_idx;
  logic [7:0]           shift;

  logic                 w_at_start;
  logic [2:0]           w_slot_next;
  logic [7:0]           w_word;
  logic                 w_miss_drop;

`ifdef SYNC_FLYWHEEL_EN
  logic [1:0]           miss_cnt;
  assign w_miss_drop = (miss_cnt == 2'd2);
`else
  assign w_miss_drop = 1'b1;
`endif

  assign w_at_start  = (cyc_cnt == '0) && (slot_idx == 3'd0);
  assign w_slot_next = slot_idx + {2'b00, (cyc_cnt == C_LAST)};

  // Word as it stands after this cycle's sample; bit 7 reaches Q directly.
  always_comb begin
    w_word           = shift;
    w_word[slot_idx] = data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cyc_cnt   <= '0;
      slot_idx  <= 3'd0;
      shift     <= 8'h00;
      Q         <= 8'h00;
      valid     <= 1'b0;
      slot_oh   <= 8'h00;
      locked    <= 1'b0;
      frame_err <= 1'b0;
`ifdef SYNC_FLYWHEEL_EN
      miss_cnt  <= 2'd0;
`endif
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      if (state == IDLE) begin
        if (sync) begin
          state    <= RUN;
          cyc_cnt  <= C_ONE;
          slot_idx <= 3'd0;
          shift    <= 8'h00;
          slot_oh  <= 8'h01;
          locked   <= 1'b1;
`ifdef SYNC_FLYWHEEL_EN
          miss_cnt <= 2'd0;
`endif
        end
      end else if (sync && !w_at_start) begin
        // Misplaced sync: drop the partial word and restart the frame here.
        frame_err <= 1'b1;
        cyc_cnt   <= C_ONE;
        slot_idx  <= 3'd0;
        shift     <= 8'h00;
        slot_oh   <= 8'h01;
`ifdef SYNC_FLYWHEEL_EN
        miss_cnt  <= 2'd0;
`endif
      end else if (!sync && w_at_start && w_miss_drop) begin
        frame_err <= 1'b1;
        state     <= IDLE;
        cyc_cnt   <= '0;
        slot_idx  <= 3'd0;
        shift     <= 8'h00;
        slot_oh   <= 8'h00;
        locked    <= 1'b0;
`ifdef SYNC_FLYWHEEL_EN
        miss_cnt  <= 2'd0;
`endif
      end else begin
`ifdef SYNC_FLYWHEEL_EN
        if (!sync && w_at_start) begin
          frame_err <= 1'b1;
          miss_cnt  <= miss_cnt + 2'd1;
        end else if (sync) begin
          miss_cnt  <= 2'd0;
        end
`endif
        cyc_cnt  <= cyc_cnt + C_ONE;
        slot_idx <= w_slot_next;
        slot_oh  <= 8'b1 << w_slot_next;
        if (cyc_cnt == C_MID) begin
          shift <= w_word;
          if (slot_idx == 3'd7) begin
            Q     <= w_word;
            valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_scan_deserializer.sv
// Directed bench for scan_deserializer with SLOT_BITS=2 (4-cycle slots, 32-cycle frames).
`default_nettype none

module tb_scan_deserializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       data_in = 1'b0;
  logic       sync = 1'b0;
  logic [7:0] Q;
  logic       valid;
  logic [7:0] slot_oh;
  logic       locked;
  logic       frame_err;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] q_model  = 8'h00;

  scan_deserializer #(.SLOT_BITS(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .sync      (sync),
    .Q         (Q),
    .valid     (valid),
    .slot_oh   (slot_oh),
    .locked    (locked),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs, then advance so outputs show that cycle's result.
  task automatic tick(input logic s, input logic d);
    sync    = s;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [7:0] word, input logic s0, input int ncyc,
                           input logic err0, input logic vexp);
    for (int i = 0; i < ncyc; i++) begin
      tick((i == 0) ? s0 : 1'b0, word[i/4]);
      if (i == 30 && vexp) q_model = word;
      check("frame_err", {31'd0, frame_err}, {31'd0, (i == 0) && err0});
      check("locked", {31'd0, locked}, 32'd1);
      check("slot_oh", {24'd0, slot_oh}, {24'd0, 8'b1 << (((i + 1) / 4) % 8)});
      check("valid", {31'd0, valid}, {31'd0, (i == 30) && vexp});
      check("q", {24'd0, Q}, {24'd0, q_model});
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_q"}, {24'd0, Q}, 32'd0);
    check({tag, "_valid"}, {31'd0, valid}, 32'd0);
    check({tag, "_slot_oh"}, {24'd0, slot_oh}, 32'd0);
    check({tag, "_locked"}, {31'd0, locked}, 32'd0);
    check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
  endtask

  initial begin
    #3;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle without sync: nothing locks, nothing is sampled.
    for (int i = 0; i < 9; i++) begin
      tick(1'b0, 1'b1);
      check("idle_locked", {31'd0, locked}, 32'd0);
      check("idle_valid", {31'd0, valid}, 32'd0);
    end

    run_frame(8'hA5, 1'b1, 32, 1'b0, 1'b1);
    run_frame(8'h3C, 1'b1, 32, 1'b0, 1'b1);
    run_frame(8'hC3, 1'b1, 32, 1'b0, 1'b1);

    // Early sync partway through slot 4 realigns without a valid.
    run_frame(8'h55, 1'b1, 18, 1'b0, 1'b0);
    run_frame(8'h81, 1'b1, 32, 1'b1, 1'b1);

`ifdef SYNC_FLYWHEEL_EN
    run_frame(8'h6E, 1'b0, 32, 1'b1, 1'b1);
    run_frame(8'h17, 1'b0, 32, 1'b1, 1'b1);
    run_frame(8'hE8, 1'b1, 32, 1'b0, 1'b1);
    run_frame(8'h42, 1'b0, 32, 1'b1, 1'b1);
    run_frame(8'h24, 1'b0, 32, 1'b1, 1'b1);
`endif
    tick(1'b0, 1'b0);
    check("miss_frame_err", {31'd0, frame_err}, 32'd1);
    check("miss_locked", {31'd0, locked}, 32'd0);
    check("miss_slot_oh", {24'd0, slot_oh}, 32'd0);
    tick(1'b0, 1'b0);
    check("miss_err_pulse", {31'd0, frame_err}, 32'd0);
    check("miss_idle", {31'd0, locked}, 32'd0);
    check("miss_q_hold", {24'd0, Q}, {24'd0, q_model});

    // Asynchronous reset during slot 5 of a fresh frame.
    run_frame(8'h5A, 1'b1, 22, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    q_model = 8'h00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, 1'b1);
      check("post_rst_valid", {31'd0, valid}, 32'd0);
      check("post_rst_locked", {31'd0, locked}, 32'd0);
      check("post_rst_slot_oh", {24'd0, slot_oh}, 32'd0);
    end
    run_frame(8'h99, 1'b1, 32, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
